// File: rtl/seg_pkg.sv
// Shared types and constants for the step-driven 7-segment display.
// SEG_HEX_EN selects a hexadecimal digit (modulus 16); otherwise the digit is decimal.
package seg_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FLASH  = 2'd1,
    BLANK  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, 1 = lit, indexed by digit value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

`ifdef SEG_HEX_EN
  localparam int MODULUS = 16;
`else
  localparam int MODULUS = 10;
`endif

  localparam logic [3:0] MOD_LAST = 4'(MODULUS - 1);

  function automatic logic [3:0] step_value(input logic [3:0] v, input logic down);
    if (down) return (v == 4'd0)     ? MOD_LAST : v - 4'd1;
    else      return (v == MOD_LAST) ? 4'd0     : v + 4'd1;
  endfunction

  function automatic logic is_wrap(input logic [3:0] v, input logic down);
    return down ? (v == 4'd0) : (v == MOD_LAST);
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-to-glyph lookup; the caller registers the result.
// Without SEG_HEX_EN, values 10-15 cannot occur and decode to all segments off.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_glyph
);

  always_comb begin
`ifdef SEG_HEX_EN
    o_glyph = GLYPH[i_value];
`else
    o_glyph = (i_value <= MOD_LAST) ? GLYPH[i_value] : 7'h00;
`endif
  end

endmodule

// File: rtl/seg_step_display.sv
// Single-digit display stepped by one-shot pulses, with a wrap flash on the decimal
// point and idle blanking. SEG_HEX_EN selects a hex digit instead of decimal.
module seg_step_display
  import seg_pkg::*;
#(
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int IDLE_CYCLES  = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_pulse,
  input  logic       dir_down,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] value
);

  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int IDLE_W  = (IDLE_CYCLES  > 1) ? $clog2(IDLE_CYCLES)  : 1;
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam bit                 IDLE_EN    = (IDLE_CYCLES != 0);

  state_t             r_state;
  logic [3:0]         r_value;
  logic [IDLE_W-1:0]  r_idle;
  logic [FLASH_W-1:0] r_flash;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic [3:0] w_next;
  logic       w_wrap;
  logic [6:0] w_glyph;

  assign w_next = step_value(r_value, dir_down);
  assign w_wrap = step_pulse && is_wrap(r_value, dir_down);

  seg_decoder u_decoder (
    .i_value (r_value),
    .o_glyph (w_glyph)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the output registers deliberately see the state from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACTIVE;
      r_value <= 4'd0;
      r_idle  <= '0;
      r_flash <= '0;
      r_seg   <= 7'h00;
      r_dp    <= 1'b0;
    end else begin
      r_seg <= (r_state == BLANK) ? 7'h00 : w_glyph;
      r_dp  <= (r_state == FLASH);

      unique case (r_state)
        ACTIVE: begin
          if (step_pulse) begin
            r_value <= w_next;
            r_idle  <= '0;
            if (w_wrap) begin
              r_flash <= FLASH_LAST;
              r_state <= FLASH;
            end
          end else if (IDLE_EN && r_idle == IDLE_LAST) begin
            r_state <= BLANK;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end

        FLASH: begin
          if (step_pulse) r_value <= w_next;
          // A wrap during the flash restarts the full flash period.
          if (w_wrap) begin
            r_flash <= FLASH_LAST;
          end else if (r_flash == '0) begin
            r_state <= ACTIVE;
            r_idle  <= '0;
          end else begin
            r_flash <= r_flash - 1'b1;
          end
        end

        BLANK: begin
          // Wake-only: the press that ends blanking does not change the digit.
          if (step_pulse) begin
            r_state <= ACTIVE;
            r_idle  <= '0;
          end
        end

        default: r_state <= ACTIVE;
      endcase
    end
  end

  assign seg_out = r_seg;
  assign dp_out  = r_dp;
  assign value   = r_value;

endmodule
